// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//
// Demand-driven right-of-way scheduler for a 4-lane intersection. One lane at
// a time gets green. Lanes are served round-robin, with min/max green timing,
// gap-out and emergency preemption. All timing and phase changes happen only
// on clk edges where the one-cycle `tick` strobe is high.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   tick           timebase strobe, one clk wide
//   req[3:0]       per-lane vehicle presence (level), bit i = lane i
//   emerg_req      emergency preemption request (level)
//   emerg_lane     lane the emergency vehicle approaches on
//   green/yellow/red[3:0]  registered lamp drives, one-hot per lane
//   active_lane    lane currently owning, or last owning, right-of-way
//   emerg_ack      high while emerg_lane is green under preemption
//   phase_state    current phase (0=ALLRED, 1=GREEN, 2=YELLOW), for debug
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic       emerg_req,
    input  logic [1:0] emerg_lane,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [1:0] active_lane,
    output logic       emerg_ack,
    output logic [1:0] phase_state
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       lane_nxt;
    logic [1:0]       rr_lane;
    logic [1:0]       cand;
    logic             rr_found;
    logic [3:0]       lane_mask;
    logic             other;
    logic             cur_req;
    logic [3:0]       green_nxt;
    logic [3:0]       yellow_nxt;
    logic             ack_nxt;

    assign phase_state = state;

    // Round-robin search starting after the last served lane. Iterating from
    // the farthest offset down lets the nearest requesting lane win.
    always_comb begin
        rr_found = 1'b0;
        rr_lane  = active_lane;
        cand     = active_lane;
        for (int k = 4; k >= 1; k--) begin
            cand = active_lane + 2'(k);
            if (req[cand]) begin
                rr_found = 1'b1;
                rr_lane  = cand;
            end
        end
    end

    assign lane_mask = 4'b0001 << active_lane;
    assign other     = |(req & ~lane_mask);
    assign cur_req   = req[active_lane];

    always_comb begin
        state_nxt = state;
        lane_nxt  = active_lane;
        cnt_nxt   = cnt;
        if (tick) begin
            unique case (state)
                ST_ALLRED: begin
                    if (cnt >= ALLRED_LAST) begin
                        // Emergency outranks round-robin.
                        if (emerg_req) begin
                            state_nxt = ST_GREEN;
                            lane_nxt  = emerg_lane;
                        end else if (rr_found) begin
                            state_nxt = ST_GREEN;
                            lane_nxt  = rr_lane;
                        end
                    end
                end
                ST_GREEN: begin
                    if (emerg_req) begin
                        // Preemption ignores GREEN_MIN; an emergency on this
                        // lane holds green indefinitely.
                        if (emerg_lane != active_lane)
                            state_nxt = ST_YELLOW;
                    end else if (other && ((cnt >= GMIN_LAST && !cur_req) ||
                                           cnt >= GMAX_LAST)) begin
                        state_nxt = ST_YELLOW;
                    end
                end
                ST_YELLOW: begin
                    if (cnt == YELLOW_LAST)
                        state_nxt = ST_ALLRED;
                end
                default: state_nxt = ST_ALLRED;
            endcase

            if (state_nxt != state)
                cnt_nxt = '0;
            else if (cnt != '1)
                cnt_nxt = cnt + 1'b1;
        end
    end

    // Lamps are decoded from the next phase so they register together with it.
    always_comb begin
        green_nxt  = 4'b0000;
        yellow_nxt = 4'b0000;
        if (state_nxt == ST_GREEN)
            green_nxt = 4'b0001 << lane_nxt;
        else if (state_nxt == ST_YELLOW)
            yellow_nxt = 4'b0001 << lane_nxt;
        ack_nxt = emerg_req && (state_nxt == ST_GREEN) && (lane_nxt == emerg_lane);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_ALLRED;
            cnt         <= '0;
            active_lane <= 2'd3;
            green       <= 4'b0000;
            yellow      <= 4'b0000;
            red         <= 4'b1111;
            emerg_ack   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            active_lane <= lane_nxt;
            green       <= green_nxt;
            yellow      <= yellow_nxt;
            red         <= ~(green_nxt | yellow_nxt);
            emerg_ack   <= ack_nxt;
        end
    end

endmodule
